// File: rtl/fpm_operand_loader.sv
// Byte-serial loader that assembles two IEEE-754 single-precision operands and
// presents them to the multiplier with a valid/ready handoff. Optional flush port under FPM_LOADER_FLUSH_EN.
module fpm_operand_loader #(
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FPM_LOADER_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [31:0]      in1,
    output logic             additional1,
    output logic [31:0]      in2,
    output logic             additional2,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         idx_reg, idx_next;
    logic [31:0]        asm_a_reg, asm_a_next;
    logic [31:0]        asm_b_reg, asm_b_next;
    logic [31:0]        in1_reg, in1_next;
    logic [31:0]        in2_reg, in2_next;
    logic               add1_reg, add1_next;
    logic               add2_reg, add2_next;
    logic               op_valid_reg, op_valid_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [31:0]        a_shifted;
    logic [31:0]        b_shifted;
    logic               byte_xfer;
    logic               handoff;
    logic               flush_req;
    logic               last_byte;

`ifdef FPM_LOADER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Each lane either takes the incoming byte or its neighbour, depending on byte order.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_ins
                    assign a_shifted[7:0] = byte_in;
                    assign b_shifted[7:0] = byte_in;
                end else begin : g_mov
                    assign a_shifted[gi*8 +: 8] = asm_a_reg[(gi-1)*8 +: 8];
                    assign b_shifted[gi*8 +: 8] = asm_b_reg[(gi-1)*8 +: 8];
                end
            end else begin : g_lsb
                if (gi == 3) begin : g_ins
                    assign a_shifted[31:24] = byte_in;
                    assign b_shifted[31:24] = byte_in;
                end else begin : g_mov
                    assign a_shifted[gi*8 +: 8] = asm_a_reg[(gi+1)*8 +: 8];
                    assign b_shifted[gi*8 +: 8] = asm_b_reg[(gi+1)*8 +: 8];
                end
            end
        end
    endgenerate

    assign byte_ready = (state_reg != PRESENT);
    assign byte_xfer  = byte_valid && byte_ready;
    assign handoff    = op_valid_reg && op_ready;
    assign last_byte  = (idx_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOAD_A;
            idx_reg      <= 2'd0;
            asm_a_reg    <= 32'd0;
            asm_b_reg    <= 32'd0;
            in1_reg      <= 32'd0;
            in2_reg      <= 32'd0;
            add1_reg     <= 1'b0;
            add2_reg     <= 1'b0;
            op_valid_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            asm_a_reg    <= asm_a_next;
            asm_b_reg    <= asm_b_next;
            in1_reg      <= in1_next;
            in2_reg      <= in2_next;
            add1_reg     <= add1_next;
            add2_reg     <= add2_next;
            op_valid_reg <= op_valid_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        asm_a_next    = asm_a_reg;
        asm_b_next    = asm_b_reg;
        in1_next      = in1_reg;
        in2_next      = in2_reg;
        add1_next     = add1_reg;
        add2_next     = add2_reg;
        op_valid_next = op_valid_reg;
        cnt_next      = cnt_reg;

        if (flush_req) begin
            // Output operand registers deliberately keep their last values.
            state_next    = LOAD_A;
            idx_next      = 2'd0;
            asm_a_next    = 32'd0;
            asm_b_next    = 32'd0;
            op_valid_next = 1'b0;
        end else begin
            case (state_reg)
                LOAD_A: begin
                    if (byte_xfer) begin
                        asm_a_next = a_shifted;
                        if (last_byte) begin
                            idx_next   = 2'd0;
                            state_next = LOAD_B;
                        end else begin
                            idx_next = idx_reg + 2'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (byte_xfer) begin
                        asm_b_next = b_shifted;
                        if (last_byte) begin
                            idx_next      = 2'd0;
                            in1_next      = asm_a_reg;
                            in2_next      = b_shifted;
                            // Zero exponent means no hidden bit (zero/denormal); Inf/NaN keep it.
                            add1_next     = |asm_a_reg[30:23];
                            add2_next     = |b_shifted[30:23];
                            op_valid_next = 1'b1;
                            state_next    = PRESENT;
                        end else begin
                            idx_next = idx_reg + 2'd1;
                        end
                    end
                end
                PRESENT: begin
                    if (handoff) begin
                        op_valid_next = 1'b0;
                        cnt_next      = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_next    = LOAD_A;
                    end
                end
                default: begin
                    state_next    = LOAD_A;
                    idx_next      = 2'd0;
                    op_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign in1         = in1_reg;
    assign in2         = in2_reg;
    assign additional1 = add1_reg;
    assign additional2 = add2_reg;
    assign op_valid    = op_valid_reg;
    assign pair_count  = cnt_reg;

endmodule

// File: tb/tb_fpm_operand_loader.sv
// Bench for fpm_operand_loader: an MSB-first and an LSB-first (3-bit counter) instance
// share one stimulus stream and are checked against a byte-queue reference model.
module tb_fpm_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        op_ready;
`ifdef FPM_LOADER_FLUSH_EN
    logic        flush;
`endif

    logic        m_byte_ready, m_add1, m_add2, m_valid;
    logic [31:0] m_in1, m_in2;
    logic [15:0] m_cnt;
    logic        l_byte_ready, l_add1, l_add2, l_valid;
    logic [31:0] l_in1, l_in2;
    logic [2:0]  l_cnt;

    always #5 clk = ~clk;

    fpm_operand_loader #(.MSB_FIRST(1), .CNT_W(16)) dut_msb (
        .clk(clk), .rst_n(rst_n),
`ifdef FPM_LOADER_FLUSH_EN
        .flush(flush),
`endif
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(m_byte_ready),
        .in1(m_in1), .additional1(m_add1), .in2(m_in2), .additional2(m_add2),
        .op_valid(m_valid), .op_ready(op_ready), .pair_count(m_cnt)
    );

    fpm_operand_loader #(.MSB_FIRST(0), .CNT_W(3)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
`ifdef FPM_LOADER_FLUSH_EN
        .flush(flush),
`endif
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(l_byte_ready),
        .in1(l_in1), .additional1(l_add1), .in2(l_in2), .additional2(l_add2),
        .op_valid(l_valid), .op_ready(op_ready), .pair_count(l_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bytes of the pair in arrival order, plus the expected presented state.
    logic [7:0]  q[$];
    logic [31:0] e_in1_m, e_in2_m, e_in1_l, e_in2_l;
    logic        e_valid;
    int          e_pairs;

    function automatic logic [31:0] word_of(input logic [7:0] b0, b1, b2, b3, input bit msb);
        return msb ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    function automatic logic [31:0] hidden(input logic [31:0] w);
        return (w[30:23] != 8'd0) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        e_in1_m = 0; e_in2_m = 0; e_in1_l = 0; e_in2_l = 0;
        e_valid = 1'b0;
        e_pairs = 0;
    endtask

    task automatic model_edge(input bit bv, input logic [7:0] b, input bit rdy, input bit fl);
        if (fl) begin
            q.delete();
            e_valid = 1'b0;
        end else if (e_valid) begin
            if (rdy) begin
                e_valid = 1'b0;
                e_pairs++;
                $display("pair %0d handed off: msb %h*%h  lsb %h*%h",
                         e_pairs, e_in1_m, e_in2_m, e_in1_l, e_in2_l);
            end
        end else if (bv) begin
            q.push_back(b);
            if (q.size() == 8) begin
                e_in1_m = word_of(q[0], q[1], q[2], q[3], 1'b1);
                e_in2_m = word_of(q[4], q[5], q[6], q[7], 1'b1);
                e_in1_l = word_of(q[0], q[1], q[2], q[3], 1'b0);
                e_in2_l = word_of(q[4], q[5], q[6], q[7], 1'b0);
                e_valid = 1'b1;
                q.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " m_ready"}, {31'd0, m_byte_ready}, {31'd0, !e_valid});
        chk({ctx, " m_valid"}, {31'd0, m_valid}, {31'd0, e_valid});
        chk({ctx, " m_in1"},   m_in1, e_in1_m);
        chk({ctx, " m_in2"},   m_in2, e_in2_m);
        chk({ctx, " m_add1"},  {31'd0, m_add1}, hidden(e_in1_m));
        chk({ctx, " m_add2"},  {31'd0, m_add2}, hidden(e_in2_m));
        chk({ctx, " m_cnt"},   {16'd0, m_cnt}, 32'(e_pairs % 65536));
        chk({ctx, " l_ready"}, {31'd0, l_byte_ready}, {31'd0, !e_valid});
        chk({ctx, " l_valid"}, {31'd0, l_valid}, {31'd0, e_valid});
        chk({ctx, " l_in1"},   l_in1, e_in1_l);
        chk({ctx, " l_in2"},   l_in2, e_in2_l);
        chk({ctx, " l_add1"},  {31'd0, l_add1}, hidden(e_in1_l));
        chk({ctx, " l_add2"},  {31'd0, l_add2}, hidden(e_in2_l));
        chk({ctx, " l_cnt"},   {29'd0, l_cnt}, 32'(e_pairs % 8));
    endtask

    // Called at posedge+1; drives inputs, takes one edge, updates model, checks.
    task automatic step(input string ctx, input bit bv, input logic [7:0] b, input bit rdy,
                        input bit fl = 1'b0);
        byte_valid = bv;
        byte_in    = b;
        op_ready   = rdy;
`ifdef FPM_LOADER_FLUSH_EN
        flush      = fl;
`endif
        @(posedge clk);
        model_edge(bv, b, rdy, fl);
        #1;
        check_all(ctx);
    endtask

    task automatic send_bytes(input string ctx, input logic [63:0] bytes, input bit rdy);
        logic [63:0] v;
        v = bytes;
        for (int i = 0; i < 8; i++) begin
            step(ctx, 1'b1, v[63-8*i -: 8], rdy);
        end
    endtask

    task automatic async_reset(input string ctx);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        byte_valid = 1'b0;
        op_ready   = 1'b0;
`ifdef FPM_LOADER_FLUSH_EN
        flush      = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all({ctx, " post"});
    endtask

    initial begin
        logic [7:0] rb;
        rst_n      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        op_ready   = 1'b0;
`ifdef FPM_LOADER_FLUSH_EN
        flush      = 1'b0;
`endif
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic load, consumer ready from the start.
        send_bytes("basic", 64'h4000_0000_4040_0000, 1'b1);
        chk("basic in1", m_in1, 32'h4000_0000);
        chk("basic in2", m_in2, 32'h4040_0000);
        chk("basic add", {30'd0, m_add1, m_add2}, 32'd3);
        step("basic handoff", 1'b1, 8'hAA, 1'b1);
        chk("basic cnt", {16'd0, m_cnt}, 32'd1);
        chk("basic valid drop", {31'd0, m_valid}, 32'd0);

        // Zero / denormal operands, then backpressure with bytes offered.
        send_bytes("zero", 64'h0000_0000_0040_0000, 1'b0);
        chk("zero add", {30'd0, m_add1, m_add2}, 32'd0);
        for (int i = 0; i < 3; i++) step("bp hold", 1'b1, 8'h55, 1'b0);
        chk("bp in2 held", m_in2, 32'h0040_0000);
        step("bp release", 1'b1, 8'h66, 1'b1);
        chk("bp cnt", {16'd0, m_cnt}, 32'd2);

        // Reset mid-load discards a partial pair.
        for (int i = 0; i < 5; i++) step("pre rst", 1'b1, 8'hF0 + 8'(i), 1'b0);
        async_reset("rst mid");
        send_bytes("after rst", 64'h3F80_0000_C000_0000, 1'b0);
        chk("after rst in1", m_in1, 32'h3F80_0000);
        chk("after rst in2", m_in2, 32'hC000_0000);
        step("after rst handoff", 1'b0, 8'h00, 1'b1);

        // LSB-first ordering, with random bubbles.
        send_bytes("order", 64'h0000_803F_0000_00C0, 1'b0);
        chk("order l_in1", l_in1, 32'h3F80_0000);
        chk("order l_in2", l_in2, 32'hC000_0000);
        step("order handoff", 1'b0, 8'h00, 1'b1);
        begin
            logic [63:0] v;
            int k;
            v = 64'h0000_803F_0000_00C0;
            k = 0;
            for (int guard = 0; guard < 200 && k < 8; guard++) begin
                if ($urandom_range(0, 2) == 0) begin
                    step("order bubble", 1'b0, 8'($urandom), 1'b0);
                end else begin
                    step("order bubbled", 1'b1, v[63-8*k -: 8], 1'b0);
                    k++;
                end
            end
            chk("order bubbles done", 32'(k), 32'd8);
            chk("order bubble l_in1", l_in1, 32'h3F80_0000);
            chk("order bubble l_in2", l_in2, 32'hC000_0000);
            step("order bubble handoff", 1'b0, 8'h00, 1'b1);
        end

`ifdef FPM_LOADER_FLUSH_EN
        // Flush mid-load, then a clean pair; flush while presenting.
        for (int i = 0; i < 6; i++) step("pre flush", 1'b1, 8'h11, 1'b0);
        step("flush load", 1'b1, 8'h22, 1'b1, 1'b1);
        send_bytes("post flush", 64'h4120_0000_BF80_0000, 1'b0);
        chk("post flush in1", m_in1, 32'h4120_0000);
        step("flush present", 1'b1, 8'h00, 1'b1, 1'b1);
        chk("flush present valid", {31'd0, m_valid}, 32'd0);
        chk("flush present in1 kept", m_in1, 32'h4120_0000);
`endif

        // Random traffic with biased exponent bytes; exercises the 3-bit counter wrap.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: rb = 8'h00;
                1: rb = 8'h7F;
                2: rb = 8'h80;
                3: rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
`ifdef FPM_LOADER_FLUSH_EN
            step("random", $urandom_range(0, 3) != 0, rb, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0);
`else
            step("random", $urandom_range(0, 3) != 0, rb, $urandom_range(0, 2) != 0);
`endif
        end
        chk("random pairs seen", 32'(e_pairs > 8), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
